// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared types and helpers for the ARM condition unit
//   cond_t           : 4-bit ARM condition field encoding (EQ..NV)
//   FLAG_N..FLAG_V   : bit positions of N,Z,C,V inside the {N,Z,C,V} flags vector
//   compute_overflow : signed overflow of an add/subtract from operand and result MSBs
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000,
    NE = 4'b0001,
    CS = 4'b0010,
    CC = 4'b0011,
    MI = 4'b0100,
    PL = 4'b0101,
    VS = 4'b0110,
    VC = 4'b0111,
    HI = 4'b1000,
    LS = 4'b1001,
    GE = 4'b1010,
    LT = 4'b1011,
    GT = 4'b1100,
    LE = 4'b1101,
    AL = 4'b1110,
    NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Overflow happens when the effective operand signs agree (b is inverted on
  // subtract) and the result sign differs from operand a.
  function automatic logic compute_overflow(input logic a_msb,
                                            input logic b_msb,
                                            input logic sub,
                                            input logic res_msb);
    return ~(a_msb ^ b_msb ^ sub) & (a_msb ^ res_msb);
  endfunction

endpackage

// File: rtl/cond_check.sv
// rtl/cond_check.sv - combinational ARM condition evaluator
//   cond    [3:0] in  : instruction condition field (cond_t encoding)
//   flags   [3:0] in  : stored {N,Z,C,V}
//   cond_ex       out : 1 when the condition passes
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  cond_t cond_e;
  logic  n, z, c, v;

  assign cond_e = cond_t'(cond);
  assign n      = flags[FLAG_N];
  assign z      = flags[FLAG_Z];
  assign c      = flags[FLAG_C];
  assign v      = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    unique case (cond_e)
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/condition_unit.sv
// rtl/condition_unit.sv - NZCV flag register, condition check and strobe gating
//   clk, reset          in  : clock (rising edge), async active-high reset
//   cond [3:0]          in  : instruction condition field
//   alu_result [W-1:0]  in  : arithmetic result
//   alu_cout            in  : carry-out (1 = no borrow on subtract)
//   alu_sub             in  : ALU performed a - b
//   a_msb, b_msb        in  : operand sign bits
//   flag_w [1:0]        in  : [1] writes N,Z  [0] writes C,V
//   pcs, reg_w, mem_w   in  : decoder requests
//   no_write            in  : compare-type op, suppresses register write
//   pc_src, reg_write, mem_write out : requests gated by the condition
//   cond_ex             out : condition passed
//   flags [3:0]         out : stored {N,Z,C,V}
module condition_unit
  import cond_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cond,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_sub,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic [1:0]       flag_w,
  input  logic             pcs,
  input  logic             reg_w,
  input  logic             mem_w,
  input  logic             no_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             mem_write,
  output logic             cond_ex,
  output logic [3:0]       flags
);

  logic [3:0] flags_d, flags_q;
  logic       n_next, z_next, c_next, v_next;

  // Condition is judged against the stored flags, never this instruction's result.
  cond_check u_cond_check (
    .cond    (cond),
    .flags   (flags_q),
    .cond_ex (cond_ex)
  );

  always_comb begin
    n_next = alu_result[WIDTH-1];
    z_next = (alu_result == '0);
    c_next = alu_cout;
    v_next = compute_overflow(a_msb, b_msb, alu_sub, alu_result[WIDTH-1]);

    flags_d = flags_q;
    if (cond_ex && flag_w[1]) begin
      flags_d[FLAG_N] = n_next;
      flags_d[FLAG_Z] = z_next;
    end
    if (cond_ex && flag_w[0]) begin
      flags_d[FLAG_C] = c_next;
      flags_d[FLAG_V] = v_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags     = flags_q;
  assign pc_src    = pcs & cond_ex;
  assign reg_write = reg_w & cond_ex & ~no_write;
  assign mem_write = mem_w & cond_ex;

endmodule

// File: doc/condition_unit.md
Name: condition_unit

Overview:
- Downstream neighbour of the ALU arithmetic stage in the ARMv4 core.
- Turns the arithmetic result and carry into NZCV flags and holds them in a flags register.
- Evaluates the instruction's 4-bit ARM condition field against the stored flags.
- Gates the decoder's PC-source, register-write and memory-write strobes, so a failed condition has no architectural effect.

Parameters:
- WIDTH, 32, ALU result width; the bench uses 8.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears the flags register
- cond  input  4  instruction condition field
- alu_result  input  WIDTH  result from the arithmetic unit
- alu_cout  input  1  carry-out from the arithmetic unit; on subtract, 1 means no borrow
- alu_sub  input  1  1 when the ALU performed a - b
- a_msb  input  1  operand a bit WIDTH-1
- b_msb  input  1  operand b bit WIDTH-1
- flag_w  input  2  flag write enables; [1] writes N,Z; [0] writes C,V
- pcs  input  1  decoder PC-source request
- reg_w  input  1  decoder register-write request
- mem_w  input  1  decoder memory-write request
- no_write  input  1  compare-type op; suppresses the register write
- pc_src  output  1  pcs & cond_ex
- reg_write  output  1  reg_w & cond_ex & ~no_write
- mem_write  output  1  mem_w & cond_ex
- cond_ex  output  1  condition passed
- flags  output  4  stored {N,Z,C,V}

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is asynchronous and active-high.
- Reset values:
  - flags = 4'b0000 immediately on reset assertion, independent of clk.
  - All outputs are combinational from flags and inputs, so after reset cond_ex follows the rules below with NZCV = 0000.
- Next-flag computation (combinational):
  - N = alu_result[WIDTH-1]
  - Z = (alu_result == 0)
  - C = alu_cout
  - V = ~(a_msb ^ b_msb ^ alu_sub) & (a_msb ^ alu_result[WIDTH-1])
- Flag update:
  - On the rising edge of clk, if cond_ex & flag_w[1], flags[3:2] <= {N,Z}.
  - On the rising edge of clk, if cond_ex & flag_w[0], flags[1:0] <= {C,V}.
  - The two halves are independent; a disabled half holds its value.
- Latency: cond_ex and the gated strobes depend on the stored flags with zero cycles of latency. Newly computed flags become visible one cycle later. An instruction never tests its own flag result; a flag-setting instruction followed by a conditional instruction on the next cycle sees the updated flags.
- Condition evaluation (cond -> cond_ex):
  - 0000 EQ Z
  - 0001 NE ~Z
  - 0010 CS C
  - 0011 CC ~C
  - 0100 MI N
  - 0101 PL ~N
  - 0110 VS V
  - 0111 VC ~V
  - 1000 HI C&~Z
  - 1001 LS ~C|Z
  - 1010 GE N==V
  - 1011 LT N!=V
  - 1100 GT ~Z&(N==V)
  - 1101 LE Z|(N!=V)
  - 1110 AL 1
  - 1111 NV 0 (defined as never; no X)
- Failed condition: flags are unchanged and pc_src, reg_write and mem_write are all 0, regardless of the input requests.
- Reset mid-operation: asserting reset in the same cycle as a flag write leaves flags at 0 (reset dominates). Deasserting reset has no effect until the next clock edge.
- Width rules: Z compares all WIDTH bits; N uses only the MSB. No outputs depend on bits beyond WIDTH.

Decomposition:
- Package cond_pkg:
  - enum cond_t (EQ..NV, 4-bit)
  - localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - function compute_overflow
- Sub-module cond_check: purely combinational; inputs cond_t and flags[3:0], output cond_ex. Instantiated once; contains the 16-way case.
- The top level holds the flags register, the next-flag logic and the strobe gating.

Test Plan (WIDTH=8):
- Subtract with flag write: reset, then alu_result=8'd7, alu_cout=1, alu_sub=1, a_msb=0, b_msb=0, cond=AL, flag_w=2'b11 (i.e. 11-4); clock -> flags=4'b0010. Then cond=CS -> cond_ex=1; cond=EQ -> cond_ex=0.
- Negative, borrow: alu_result=8'd249, alu_cout=0, alu_sub=1, a_msb=0, b_msb=0, flag_w=2'b11 (i.e. 4-11); clock -> flags=4'b1000. Then cond=LT -> 1, GE -> 0, CC -> 1.
- Signed overflow: alu_result=8'd128, alu_cout=0, alu_sub=0, a_msb=0, b_msb=0, flag_w=2'b11 (i.e. 127+1); clock -> flags=4'b1001. Then cond=VS -> 1, GE -> 1.
- Failed-condition gating and partial writes:
  - flags=0100, cond=NE, pcs=reg_w=mem_w=1, flag_w=2'b11 -> pc_src=reg_write=mem_write=0; after clock flags still 0100.
  - flag_w=2'b10 with cond=AL -> only N,Z change.
- Async reset and NV:
  - flags=1111; assert reset between clock edges -> flags=0000 before the next edge. cond=NE -> 1, cond=NV -> 0.
  - no_write=1, reg_w=1, cond=AL -> reg_write=0.
